// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
//
// Round-robin arbiter sharing one 8:1 mux among eight requesters. Requester i
// owns mux data input i (0 -> A ... 7 -> H). One requester owns the mux at a
// time. The selects follow the owner index. A grant lasts at most HOLD_MAX
// cycles, so no requester can starve the others.
//
// Parameters:
//   HOLD_MAX  maximum consecutive cycles of one grant (legal 1..255)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   req[7:0]  request vector, bit i = requester i wants the mux
//   gnt[7:0]  registered one-hot grant, all zero when no grant is active
//   S2,S1,S0  registered mux selects = owner index (held after release)
//   busy      registered, high while a grant is active
module mux8_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       S2,
  output logic       S1,
  output logic       S0,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;

  logic       found;
  logic [2:0] win;
  logic [2:0] cand;

  // Round-robin scan: ptr+1 first, ptr itself last, so the previous owner has
  // the lowest priority but is still re-granted when it is the only requester.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that left
    // one unassigned would infer a latch.
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // Selects change only together with a new grant, never while idle,
        // which keeps the mux output glitch-free for the incoming owner.
        if (found) begin
          gnt_d   = 8'(1) << win;
          sel_d   = win;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel_q] || cnt_q == HOLD_LAST) begin
          gnt_d   = 8'h00;
          busy_d  = 1'b0;
          ptr_d   = sel_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other, independent of block order.
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      busy_q  <= 1'b0;
      ptr_q   <= 3'd7;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt          = gnt_q;
  assign {S2, S1, S0} = sel_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter
//
// Directed bench for mux8_rr_arbiter. Three instances share clk/rst/req:
// u_dut (HOLD_MAX=8), u_dut4 (HOLD_MAX=4) and u_dut1 (HOLD_MAX=1). Each step
// only checks the instance the step is aimed at. Inputs change and outputs
// are sampled 1ns after the rising edge.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;

  logic [7:0] gnt, gnt4, gnt1;
  logic       s2, s1, s0, s2_4, s1_4, s0_4, s2_1, s1_1, s0_1;
  logic       busy, busy4, busy1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter u_dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .S2(s2), .S1(s1), .S0(s0), .busy(busy)
  );

  mux8_rr_arbiter #(.HOLD_MAX(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt4),
    .S2(s2_4), .S1(s1_4), .S0(s0_4), .busy(busy4)
  );

  mux8_rr_arbiter #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt1),
    .S2(s2_1), .S1(s1_1), .S0(s0_1), .busy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full state of the HOLD_MAX=8 instance: grant, select index, busy.
  task automatic check_main(input string tag, input logic [7:0] g, input logic [2:0] s, input logic b);
    check({tag, ".gnt"}, gnt, g);
    check({tag, ".sel"}, {5'd0, s2, s1, s0}, {5'd0, s});
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state on all three instances.
    do_reset();
    check_main("rst", 8'h00, 3'd0, 1'b0);
    check("rst4.gnt", gnt4, 8'h00);
    check("rst1.gnt", gnt1, 8'h00);

    // Single requester 0: one-cycle latency, release the edge after drop.
    req = 8'h01;
    step();
    check_main("r0.grant", 8'h01, 3'd0, 1'b1);
    req = 8'h00;
    step();
    check_main("r0.release", 8'h00, 3'd0, 1'b0);
    step();
    check_main("r0.idle_hold", 8'h00, 3'd0, 1'b0);

    // All eight requesting: 0..7 then 0 again, 8 cycles each, 1-cycle gap.
    do_reset();
    req = 8'hFF;
    step();
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 8; c++) begin
        check_main($sformatf("ff.g%0d.c%0d", g, c), 8'(1) << (g % 8), 3'(g % 8), 1'b1);
        step();
      end
      check_main($sformatf("ff.gap%0d", g), 8'h00, 3'(g % 8), 1'b0);
      step();
    end

    // Requesters 2 and 5; 2 drops after 3 granted cycles.
    do_reset();
    req = 8'h24;
    step();
    for (int c = 0; c < 3; c++) begin
      check_main($sformatf("r25.own2.c%0d", c), 8'h04, 3'd2, 1'b1);
      if (c < 2) step();
    end
    req = 8'h20;
    step();
    check_main("r25.gap", 8'h00, 3'd2, 1'b0);
    step();
    check_main("r25.own5", 8'h20, 3'd5, 1'b1);

    // Only requester 6 on HOLD_MAX=4: 4 granted, 1 gap, re-granted.
    do_reset();
    req = 8'h40;
    step();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("r6.h4.r%0d.c%0d.gnt", r, c), gnt4, 8'h40);
        check($sformatf("r6.h4.r%0d.c%0d.sel", r, c), {5'd0, s2_4, s1_4, s0_4}, 8'd6);
        step();
      end
      check($sformatf("r6.h4.gap%0d", r), gnt4, 8'h00);
      check($sformatf("r6.h4.gap%0d.busy", r), {7'd0, busy4}, 8'd0);
      step();
    end

    // HOLD_MAX=1: every grant lasts exactly one cycle, alternating 0 and 1.
    do_reset();
    req = 8'h03;
    step();
    check("h1.g0", gnt1, 8'h01);
    step();
    check("h1.gap0", gnt1, 8'h00);
    step();
    check("h1.g1", gnt1, 8'h02);
    step();
    check("h1.gap1", gnt1, 8'h00);
    step();
    check("h1.g2", gnt1, 8'h01);

    // Reset in the middle of a grant to requester 4, then 4 and 7 compete.
    do_reset();
    req = 8'h10;
    step();
    check_main("mid.own4", 8'h10, 3'd4, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_main("mid.rst", 8'h00, 3'd0, 1'b0);
    req = 8'h90;
    step();
    check_main("mid.first", 8'h10, 3'd4, 1'b1);

    // Fairness: requester 3 times out with 0..3 requesting; 0 wins next.
    do_reset();
    req = 8'h08;
    step();
    check_main("fair.own3", 8'h08, 3'd3, 1'b1);
    req = 8'h0F;
    for (int c = 1; c < 8; c++) begin
      step();
      check_main($sformatf("fair.hold.c%0d", c), 8'h08, 3'd3, 1'b1);
    end
    step();
    check_main("fair.gap", 8'h00, 3'd3, 1'b0);
    step();
    check_main("fair.next", 8'h01, 3'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
